// File: rtl/axi4_slave_bresp_scheduler.sv
// ---------------------------------------------------------------------------
// axi4_slave_bresp_scheduler
//
// Purpose:
//   Write-response scheduler for the AXI4 slave agent/BFM. Write completions
//   (BID, BRESP, QoS) are collected into a compacting queue. Index 0 is always
//   the oldest entry. A B-channel holding register (bvalid/bid/bresp) is
//   reloaded from the queue whenever it is free or being handshaken.
//   Selection follows resp_mode:
//     2'b00 / 2'b01 : in order (index 0)
//     2'b10 / 2'b11 : write out-of-order. The lowest index whose ID differs
//                     from the last issued ID wins. If there is none,
//                     index 0 wins.
//   Any entry picked this way is the oldest of its ID, so per-ID order holds.
//
// Optional feature (macro AXI4_BRESP_QOS_EN):
//   In the out-of-order modes, the pick is the highest-QoS entry among those
//   that are the oldest of their ID. Ties go to the lowest index. The
//   last-ID rule is not used. Without the macro, cmp_qos is ignored.
//
// Ports:
//   aclk, areset            clock, synchronous active-high reset
//   resp_mode[1:0]          response ordering mode, sampled at each load
//   cmp_valid/cmp_ready     completion handshake
//   cmp_id/cmp_resp/cmp_qos completion payload
//   bvalid/bready/bid/bresp AXI4 B channel
//   count                   queued entries (holding register excluded)
//   empty/full              count == 0 / count == DEPTH
// ---------------------------------------------------------------------------
module axi4_slave_bresp_scheduler #(
    parameter int ID_WIDTH  = 4,
    parameter int DEPTH     = 8,
    parameter int CNT_WIDTH = 5
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic [1:0]           resp_mode,
    input  logic                 cmp_valid,
    output logic                 cmp_ready,
    input  logic [ID_WIDTH-1:0]  cmp_id,
    input  logic [1:0]           cmp_resp,
    input  logic [3:0]           cmp_qos,
    output logic                 bvalid,
    input  logic                 bready,
    output logic [ID_WIDTH-1:0]  bid,
    output logic [1:0]           bresp,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 empty,
    output logic                 full
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Queue storage
    logic [ID_WIDTH-1:0]  r_id   [DEPTH];
    logic [1:0]           r_resp [DEPTH];
    logic [CNT_WIDTH-1:0] r_count;

    // Holding register and last issued ID
    logic                 r_bvalid;
    logic [ID_WIDTH-1:0]  r_bid;
    logic [1:0]           r_bresp;
    logic [ID_WIDTH-1:0]  r_last_id;

    logic [ID_WIDTH-1:0]  w_id_next   [DEPTH];
    logic [1:0]           w_resp_next [DEPTH];
    logic [DEPTH-1:0]     w_valid;
    logic                 w_push;
    logic                 w_load;
    logic                 w_found;
    logic [IDX_W-1:0]     w_sel;
    logic [CNT_WIDTH-1:0] w_wr_idx;

    assign cmp_ready = (r_count != CNT_WIDTH'(DEPTH)) && !areset;
    assign w_push    = cmp_valid && cmp_ready;
    // The holding register takes a new entry when it is empty or draining.
    assign w_load    = (r_count != '0) && (!r_bvalid || bready);
    // A same-cycle push lands after compaction.
    assign w_wr_idx  = r_count - CNT_WIDTH'(w_load);

    assign bvalid = r_bvalid;
    assign bid    = r_bid;
    assign bresp  = r_bresp;
    assign count  = r_count;
    assign empty  = (r_count == '0);
    assign full   = (r_count == CNT_WIDTH'(DEPTH));

    // Occupancy mask, based on the count before this cycle's push.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
            assign w_valid[gi] = (CNT_WIDTH'(gi) < r_count);
        end
    endgenerate

`ifdef AXI4_BRESP_QOS_EN
    logic [3:0]       r_qos      [DEPTH];
    logic [3:0]       w_qos_next [DEPTH];
    logic [DEPTH-1:0] w_elig;
    logic [3:0]       w_best;
    logic             w_unused_last;

    // The last-ID rule does not apply in this build.
    assign w_unused_last = ^r_last_id;

    // Only the oldest entry of each ID may be picked.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_elig[i] = w_valid[i];
            for (int j = 0; j < i; j++) begin
                if (w_valid[j] && (r_id[j] == r_id[i])) begin
                    w_elig[i] = 1'b0;
                end
            end
        end
    end

    // Highest QoS wins. The strict compare keeps ties on the lowest index.
    always_comb begin
        w_sel   = '0;
        w_best  = '0;
        w_found = 1'b0;
        if (resp_mode[1]) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_elig[i] && (!w_found || (r_qos[i] > w_best))) begin
                    w_sel   = IDX_W'(i);
                    w_best  = r_qos[i];
                    w_found = 1'b1;
                end
            end
        end
    end
`else
    logic w_unused_qos;

    assign w_unused_qos = ^cmp_qos;

    // Pick the first entry whose ID differs from the last issued ID.
    // That entry is the oldest of its ID, because every earlier entry
    // carries last_id.
    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        if (resp_mode[1]) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!w_found && w_valid[i] && (r_id[i] != r_last_id)) begin
                    w_sel   = IDX_W'(i);
                    w_found = 1'b1;
                end
            end
        end
    end
`endif

    // Compaction: on a load, entries at or above the selected index shift
    // down by one. The push then writes at the post-compaction tail.
    always_comb begin
        int src;
        for (int i = 0; i < DEPTH; i++) begin
            src = (i == DEPTH - 1) ? i : i + 1;
            w_id_next[i]   = r_id[i];
            w_resp_next[i] = r_resp[i];
`ifdef AXI4_BRESP_QOS_EN
            w_qos_next[i]  = r_qos[i];
`endif
            if (w_load && (IDX_W'(i) >= w_sel)) begin
                w_id_next[i]   = r_id[src];
                w_resp_next[i] = r_resp[src];
`ifdef AXI4_BRESP_QOS_EN
                w_qos_next[i]  = r_qos[src];
`endif
            end
            if (w_push && (w_wr_idx == CNT_WIDTH'(i))) begin
                w_id_next[i]   = cmp_id;
                w_resp_next[i] = cmp_resp;
`ifdef AXI4_BRESP_QOS_EN
                w_qos_next[i]  = cmp_qos;
`endif
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_id[i]   <= '0;
                r_resp[i] <= '0;
`ifdef AXI4_BRESP_QOS_EN
                r_qos[i]  <= '0;
`endif
            end
            r_count   <= '0;
            r_bvalid  <= 1'b0;
            r_bid     <= '0;
            r_bresp   <= '0;
            r_last_id <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_id[i]   <= w_id_next[i];
                r_resp[i] <= w_resp_next[i];
`ifdef AXI4_BRESP_QOS_EN
                r_qos[i]  <= w_qos_next[i];
`endif
            end
            r_count <= r_count + CNT_WIDTH'(w_push) - CNT_WIDTH'(w_load);
            if (w_load) begin
                r_bvalid  <= 1'b1;
                r_bid     <= r_id[w_sel];
                r_bresp   <= r_resp[w_sel];
                r_last_id <= r_id[w_sel];
            end else if (bready) begin
                r_bvalid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi4_slave_bresp_scheduler.sv
// ---------------------------------------------------------------------------
// Testbench for axi4_slave_bresp_scheduler.
// The reference model keeps the pending completions in a plain queue. Each
// cycle it picks the next B response from the ordering rules and pushes it
// onto a scoreboard queue. A monitor on the falling edge compares the DUT
// B channel and status outputs against the scoreboard and the model.
// ---------------------------------------------------------------------------
module tb_axi4_slave_bresp_scheduler;

    localparam int ID_WIDTH  = 4;
    localparam int DEPTH     = 8;
    localparam int CNT_WIDTH = 5;

    logic                 aclk;
    logic                 areset;
    logic [1:0]           resp_mode;
    logic                 cmp_valid;
    logic                 cmp_ready;
    logic [ID_WIDTH-1:0]  cmp_id;
    logic [1:0]           cmp_resp;
    logic [3:0]           cmp_qos;
    logic                 bvalid;
    logic                 bready;
    logic [ID_WIDTH-1:0]  bid;
    logic [1:0]           bresp;
    logic [CNT_WIDTH-1:0] count;
    logic                 empty;
    logic                 full;

    axi4_slave_bresp_scheduler #(
        .ID_WIDTH (ID_WIDTH),
        .DEPTH    (DEPTH),
        .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .aclk     (aclk),
        .areset   (areset),
        .resp_mode(resp_mode),
        .cmp_valid(cmp_valid),
        .cmp_ready(cmp_ready),
        .cmp_id   (cmp_id),
        .cmp_resp (cmp_resp),
        .cmp_qos  (cmp_qos),
        .bvalid   (bvalid),
        .bready   (bready),
        .bid      (bid),
        .bresp    (bresp),
        .count    (count),
        .empty    (empty),
        .full     (full)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    typedef struct {
        int id;
        int resp;
        int qos;
    } ent_t;

    ent_t mq[$];     // model of pending completions, index 0 oldest
    ent_t sb_q[$];   // expected B beats, in order
    ent_t log_q[$];  // B beats observed on the DUT
    bit   m_hv;
    int   m_last;
    int   m_accepts;
    bit   mon_en;
    int   n_checks;
    int   n_errors;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Next response according to the ordering rules.
    function automatic int pick(input logic [1:0] mode);
        int best;
        bit older;
        best = 0;
        if (!mode[1]) return 0;
`ifdef AXI4_BRESP_QOS_EN
        best = -1;
        for (int i = 0; i < mq.size(); i++) begin
            older = 1'b0;
            for (int j = 0; j < i; j++)
                if (mq[j].id == mq[i].id) older = 1'b1;
            if (!older && (best < 0 || mq[i].qos > mq[best].qos)) best = i;
        end
        return best;
`else
        for (int i = 0; i < mq.size(); i++)
            if (mq[i].id != m_last) return i;
        return best;
`endif
    endfunction

    // Reference model, evaluated at each rising edge.
    initial begin
        bit   push;
        bit   load;
        int   s;
        ent_t e;
        m_hv = 1'b0; m_last = 0; m_accepts = 0; mon_en = 1'b0;
        forever begin
            @(posedge aclk);
            if (areset) begin
                mq.delete();
                sb_q.delete();
                m_hv   = 1'b0;
                m_last = 0;
            end else begin
                push = cmp_valid && (mq.size() < DEPTH);
                load = (mq.size() > 0) && (!m_hv || bready);
                if (load) begin
                    s = pick(resp_mode);
                    sb_q.push_back(mq[s]);
                    m_last = mq[s].id;
                    mq.delete(s);
                    m_hv = 1'b1;
                end else if (m_hv && bready) begin
                    m_hv = 1'b0;
                end
                if (push) begin
                    e.id = int'(cmp_id); e.resp = int'(cmp_resp); e.qos = int'(cmp_qos);
                    mq.push_back(e);
                    m_accepts++;
                end
            end
            mon_en = 1'b1;
        end
    end

    // Monitor: compare outputs on the falling edge and pop on a B handshake.
    initial begin
        ent_t e;
        forever begin
            @(negedge aclk);
            if (mon_en) begin
                chk("bvalid", int'(bvalid), int'(m_hv));
                chk("count", int'(count), mq.size());
                chk("empty", int'(empty), int'(mq.size() == 0));
                chk("full", int'(full), int'(mq.size() == DEPTH));
                chk("cmp_ready", int'(cmp_ready), int'(!areset && mq.size() < DEPTH));
                if (bvalid) begin
                    if (sb_q.size() == 0) begin
                        chk("b_unexpected", 1, 0);
                    end else begin
                        chk("bid", int'(bid), sb_q[0].id);
                        chk("bresp", int'(bresp), sb_q[0].resp);
                        if (bready && !areset) begin
                            e.id = int'(bid); e.resp = int'(bresp); e.qos = 0;
                            log_q.push_back(e);
                            $display("B beat id=%0d resp=%0d", bid, bresp);
                            void'(sb_q.pop_front());
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        areset    = 1'b1;
        cmp_valid = 1'b0;
        tick();
        areset    = 1'b0;
    endtask

    task automatic push_one(input int id, input int resp, input int qos);
        int a;
        int n;
        a = m_accepts;
        n = 0;
        cmp_valid = 1'b1;
        cmp_id    = ID_WIDTH'(id);
        cmp_resp  = 2'(resp);
        cmp_qos   = 4'(qos);
        do begin
            tick();
            n++;
        end while (m_accepts == a && n < 50);
        cmp_valid = 1'b0;
        if (m_accepts == a) chk("push_timeout", 0, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        cmp_valid = 1'b0;
        bready    = 1'b1;
        while ((mq.size() != 0 || m_hv) && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("drain_timeout", 0, 1);
    endtask

    task automatic exp_log(input string nm, input int k, input int id, input int resp);
        chk({nm, "_id"},   (k < log_q.size()) ? log_q[k].id   : -1, id);
        chk({nm, "_resp"}, (k < log_q.size()) ? log_q[k].resp : -1, resp);
    endtask

    initial begin
        int target;
        int n;
        n_checks = 0; n_errors = 0;
        areset = 1'b1; resp_mode = 2'b00; cmp_valid = 1'b0; bready = 1'b0;
        cmp_id = '0; cmp_resp = '0; cmp_qos = '0;

        // Reset, idle
        tick(); tick();
        areset = 1'b0;
        #1;
        chk("rst_bvalid", int'(bvalid), 0);
        chk("rst_bid", int'(bid), 0);
        chk("rst_bresp", int'(bresp), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_cmp_ready", int'(cmp_ready), 1);

        // In-order drain and first-response latency
        do_reset();
        resp_mode = 2'b00; bready = 1'b1; log_q.delete();
        cmp_valid = 1'b1; cmp_id = 4'd3; cmp_resp = 2'd0; cmp_qos = 4'd0;
        tick();
        chk("lat_after_accept_bvalid", int'(bvalid), 0);
        cmp_id = 4'd5; cmp_resp = 2'd2;
        tick();
        chk("lat_next_edge_bvalid", int'(bvalid), 1);
        cmp_id = 4'd3; cmp_resp = 2'd1;
        tick();
        cmp_valid = 1'b0;
        drain();
        chk("io_beats", log_q.size(), 3);
        exp_log("io0", 0, 3, 0);
        exp_log("io1", 1, 5, 2);
        exp_log("io2", 2, 3, 1);

        // Out-of-order with a repeated ID
        do_reset();
        resp_mode = 2'b11; bready = 1'b0; log_q.delete();
        push_one(2, 1, 0);
        push_one(2, 2, 0);
        push_one(7, 3, 0);
        tick();
        chk("ooo_count", int'(count), 2);
        drain();
        chk("ooo_beats", log_q.size(), 3);
`ifdef AXI4_BRESP_QOS_EN
        exp_log("ooo0", 0, 2, 1);
        exp_log("ooo1", 1, 2, 2);
        exp_log("ooo2", 2, 7, 3);
`else
        exp_log("ooo0", 0, 2, 1);
        exp_log("ooo1", 1, 7, 3);
        exp_log("ooo2", 2, 2, 2);
`endif

        // QoS arbitration (mode 10), with a dummy entry occupying the holding register
        do_reset();
        resp_mode = 2'b10; bready = 1'b0; log_q.delete();
        push_one(0, 0, 0);
        push_one(1, 1, 2);
        push_one(4, 2, 9);
        push_one(1, 3, 15);
        drain();
        chk("qos_beats", log_q.size(), 4);
        exp_log("qos0", 0, 0, 0);
`ifdef AXI4_BRESP_QOS_EN
        exp_log("qos1", 1, 4, 2);
        exp_log("qos2", 2, 1, 1);
        exp_log("qos3", 3, 1, 3);
`else
        exp_log("qos1", 1, 1, 1);
        exp_log("qos2", 2, 4, 2);
        exp_log("qos3", 3, 1, 3);
`endif

        // Full and backpressure
        do_reset();
        resp_mode = 2'b00; bready = 1'b0;
        target = m_accepts + 9;
        cmp_valid = 1'b1; cmp_resp = 2'd0; cmp_qos = 4'd0;
        n = 0;
        while (m_accepts < target && n < 50) begin
            cmp_id = ID_WIDTH'(n);
            tick();
            n++;
        end
        cmp_valid = 1'b0;
        chk("full_count", int'(count), 8);
        chk("full_flag", int'(full), 1);
        chk("full_cmp_ready", int'(cmp_ready), 0);
        chk("full_bvalid", int'(bvalid), 1);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("pulse_count", int'(count), 7);
        chk("pulse_full", int'(full), 0);
        chk("pulse_cmp_ready", int'(cmp_ready), 1);
        push_one(1, 0, 0);
        chk("refill_count", int'(count), 8);
        drain();

        // Reset in the middle of operation
        do_reset();
        bready = 1'b0;
        for (int i = 0; i < 5; i++) push_one(i, i % 4, 0);
        chk("mid_count", int'(count), 4);
        chk("mid_bvalid", int'(bvalid), 1);
        areset = 1'b1;
        tick();
        areset = 1'b0;
        #1;
        chk("mid_rst_bvalid", int'(bvalid), 0);
        chk("mid_rst_count", int'(count), 0);
        chk("mid_rst_empty", int'(empty), 1);
        log_q.delete();
        bready = 1'b1;
        repeat (5) tick();
        chk("mid_rst_no_beats", log_q.size(), 0);

        // Randomized traffic checked by the model and monitor
        for (int c = 0; c < 3000; c++) begin
            areset = ($urandom_range(0, 499) == 0);
            if (c % 64 == 0) resp_mode = 2'($urandom_range(0, 3));
            cmp_valid = ($urandom_range(0, 3) != 0);
            cmp_id    = ID_WIDTH'($urandom_range(0, 3));
            cmp_resp  = 2'($urandom_range(0, 3));
            cmp_qos   = 4'($urandom_range(0, 15));
            bready    = ($urandom_range(0, 3) != 0);
            tick();
        end
        areset = 1'b0;
        drain();
        tick();
        chk("final_count", int'(count), 0);
        chk("final_bvalid", int'(bvalid), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
